// File: rtl/predecode_stage_n.sv
// N-lane pre-decode stage between fetch and rename: per-lane operand/immediate/FU extraction,
// taken-branch lane cut-off and a 2-entry skid buffer behind a valid/ready handshake.
module predecode_stage_n #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned GHR_W  = 8,
    parameter int unsigned RA_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_valid,
    input  logic [32*LANES-1:0]       in_inst,
    input  logic [ADDR_W*LANES-1:0]   in_pc,
    input  logic [LANES-1:0]          in_pred_taken,
    input  logic [ADDR_W*LANES-1:0]   in_pred_target,
    input  logic [GHR_W*LANES-1:0]    in_pred_hist,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_valid,
    output logic [32*LANES-1:0]       out_inst,
    output logic [ADDR_W*LANES-1:0]   out_pc,
    output logic [LANES-1:0]          out_pred_taken,
    output logic [ADDR_W*LANES-1:0]   out_pred_target,
    output logic [GHR_W*LANES-1:0]    out_pred_hist,
    output logic [2*LANES-1:0]        out_fu_type,
    output logic [RA_W*LANES-1:0]     out_rs1,
    output logic [RA_W*LANES-1:0]     out_rs2,
    output logic [RA_W*LANES-1:0]     out_rd,
    output logic [32*LANES-1:0]       out_imm,
    output logic [LANES-1:0]          out_use_imm,
    output logic [LANES-1:0]          out_rs1_is_fp,
    output logic [LANES-1:0]          out_rs2_is_fp,
    output logic [LANES-1:0]          out_rd_is_fp,
    output logic [LANES-1:0]          out_is_branch,
    output logic [LANES-1:0]          out_illegal
);

    localparam logic [1:0] AluTypeInt = 2'd0;
    localparam logic [1:0] AluTypeMul = 2'd1;
    localparam logic [1:0] AluTypeMem = 2'd2;
    localparam logic [1:0] AluTypeFo  = 2'd3;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpLoadFp  = 7'b0000111;
    localparam logic [6:0] OpStoreFp = 7'b0100111;
    localparam logic [6:0] OpOpFp    = 7'b1010011;
    localparam logic [6:0] OpMadd    = 7'b1000011;
    localparam logic [6:0] OpMsub    = 7'b1000111;
    localparam logic [6:0] OpNmsub   = 7'b1001011;
    localparam logic [6:0] OpNmadd   = 7'b1001111;

    typedef struct packed {
        logic              valid;
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
        logic [GHR_W-1:0]  pred_hist;
        logic [1:0]        fu_type;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [31:0]       imm;
        logic              use_imm;
        logic              rs1_is_fp;
        logic              rs2_is_fp;
        logic              rd_is_fp;
        logic              is_branch;
        logic              illegal;
    } lane_t;

    typedef lane_t [LANES-1:0] batch_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    function automatic lane_t decode_lane(input logic [31:0] inst);
        lane_t      d;
        logic [6:0] op;
        logic [4:0] f5;
        logic       csr_imm;
        d       = '0;
        op      = inst[6:0];
        f5      = inst[31:27];
        csr_imm = (op == OpSystem) && inst[14];
        d.inst  = inst;
        d.rs1   = RA_W'(inst[19:15]);
        d.rd    = RA_W'(inst[11:7]);
        case (op)
            OpLui, OpAuipc: begin
                d.rs1     = '0;
                d.imm     = {inst[31:12], 12'b0};
                d.use_imm = 1'b1;
            end
            OpJal: begin
                d.rs1       = '0;
                d.imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                d.use_imm   = 1'b1;
                d.is_branch = 1'b1;
            end
            OpJalr: begin
                d.imm       = {{20{inst[31]}}, inst[31:20]};
                d.use_imm   = 1'b1;
                d.is_branch = 1'b1;
            end
            OpBranch: begin
                d.rs2       = RA_W'(inst[24:20]);
                d.rd        = '0;
                d.imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.use_imm   = 1'b1;
                d.is_branch = 1'b1;
            end
            OpLoad, OpMiscMem: begin
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.use_imm = 1'b1;
                d.fu_type = AluTypeMem;
            end
            OpStore: begin
                d.rs2     = RA_W'(inst[24:20]);
                d.rd      = '0;
                d.imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.use_imm = 1'b1;
                d.fu_type = AluTypeMem;
            end
            OpImm: begin
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.use_imm = 1'b1;
            end
            OpOp: begin
                d.rs2     = RA_W'(inst[24:20]);
                d.fu_type = (inst[31:25] == 7'b0000001) ? AluTypeMul : AluTypeInt;
            end
            OpSystem: begin
                if (csr_imm) begin
                    d.rs1     = '0;
                    d.imm     = {27'b0, inst[19:15]};
                    d.use_imm = 1'b1;
                end else begin
                    d.imm = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OpLoadFp: begin
                d.imm      = {{20{inst[31]}}, inst[31:20]};
                d.fu_type  = AluTypeFo;
                d.rd_is_fp = 1'b1;
            end
            OpStoreFp: begin
                d.rs2       = RA_W'(inst[24:20]);
                d.rd        = '0;
                d.imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.fu_type   = AluTypeFo;
                d.rs2_is_fp = 1'b1;
            end
            OpOpFp: begin
                d.rs2       = RA_W'(inst[24:20]);
                d.fu_type   = AluTypeFo;
                // int->fp moves/converts read an integer source; compares/fp->int write one
                d.rs1_is_fp = !(f5 == 5'b11010 || f5 == 5'b11110);
                d.rs2_is_fp = 1'b1;
                d.rd_is_fp  = !(f5 == 5'b10100 || f5 == 5'b11000 || f5 == 5'b11100);
            end
            OpMadd, OpMsub, OpNmsub, OpNmadd: begin
                d.rs2       = RA_W'(inst[24:20]);
                d.fu_type   = AluTypeFo;
                d.rs1_is_fp = 1'b1;
                d.rs2_is_fp = 1'b1;
                d.rd_is_fp  = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end
        if (d.illegal) begin
            d         = '0;
            d.inst    = inst;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    state_e         state_q, state_d;
    batch_t         slot0_q, slot0_d;
    batch_t         slot1_q, slot1_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [LANES-1:0] cut_valid;
    batch_t         new_batch;
    logic           push;
    logic           pop;

    always_comb begin
        logic taken_seen;
        taken_seen = 1'b0;
        cut_valid  = '0;
        new_batch  = '0;
        for (int i = 0; i < LANES; i++) begin
            cut_valid[i] = in_lane_valid[i] & ~taken_seen;
            if (cut_valid[i]) begin
                new_batch[i]             = decode_lane(in_inst[i*32 +: 32]);
                new_batch[i].valid       = 1'b1;
                new_batch[i].pc          = in_pc[i*ADDR_W +: ADDR_W];
                new_batch[i].pred_taken  = in_pred_taken[i];
                new_batch[i].pred_target = in_pred_target[i*ADDR_W +: ADDR_W];
                new_batch[i].pred_hist   = in_pred_hist[i*GHR_W +: GHR_W];
                if (in_pred_taken[i]) begin
                    taken_seen = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push    = in_valid & in_ready_q & ~flush & (|cut_valid);
        pop     = out_valid_q & out_ready;
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        slot0_d = new_batch;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        slot0_d = new_batch;
                    end else if (push) begin
                        slot1_d = new_batch;
                        state_d = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            slot0_q     <= '0;
            slot1_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            out_lane_valid[i]                       = slot0_q[i].valid;
            out_inst[i*32 +: 32]                    = slot0_q[i].inst;
            out_pc[i*ADDR_W +: ADDR_W]              = slot0_q[i].pc;
            out_pred_taken[i]                       = slot0_q[i].pred_taken;
            out_pred_target[i*ADDR_W +: ADDR_W]     = slot0_q[i].pred_target;
            out_pred_hist[i*GHR_W +: GHR_W]         = slot0_q[i].pred_hist;
            out_fu_type[i*2 +: 2]                   = slot0_q[i].fu_type;
            out_rs1[i*RA_W +: RA_W]                 = slot0_q[i].rs1;
            out_rs2[i*RA_W +: RA_W]                 = slot0_q[i].rs2;
            out_rd[i*RA_W +: RA_W]                  = slot0_q[i].rd;
            out_imm[i*32 +: 32]                     = slot0_q[i].imm;
            out_use_imm[i]                          = slot0_q[i].use_imm;
            out_rs1_is_fp[i]                        = slot0_q[i].rs1_is_fp;
            out_rs2_is_fp[i]                        = slot0_q[i].rs2_is_fp;
            out_rd_is_fp[i]                         = slot0_q[i].rd_is_fp;
            out_is_branch[i]                        = slot0_q[i].is_branch;
            out_illegal[i]                          = slot0_q[i].illegal;
        end
    end

endmodule

// File: tb/tb_predecode_stage_n.sv
// Self-checking bench for predecode_stage_n: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based reference of the stage.
module tb_predecode_stage_n;

    localparam int L  = 2;
    localparam int AW = 32;
    localparam int GW = 8;
    localparam int RW = 5;

    localparam int O_LUI = 'h37, O_AUIPC = 'h17, O_JAL = 'h6f, O_JALR = 'h67, O_BR = 'h63;
    localparam int O_LD = 'h03, O_ST = 'h23, O_IMM = 'h13, O_OP = 'h33, O_MISC = 'h0f;
    localparam int O_SYS = 'h73, O_LDFP = 'h07, O_STFP = 'h27, O_OPFP = 'h53;
    localparam int O_MADD = 'h43, O_MSUB = 'h47, O_NMSUB = 'h4b, O_NMADD = 'h4f;

    typedef struct packed {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [7:0]  hist;
        logic [1:0]  fu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        ui, r1f, r2f, rdf, br, ill;
    } ml_t;
    typedef ml_t [L-1:0] batch_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [L-1:0]    in_lane_valid = '0, in_pred_taken = '0;
    logic [32*L-1:0] in_inst = '0;
    logic [AW*L-1:0] in_pc = '0, in_pred_target = '0;
    logic [GW*L-1:0] in_pred_hist = '0;
    logic [L-1:0]    out_lane_valid, out_pred_taken, out_use_imm, out_rs1_is_fp;
    logic [L-1:0]    out_rs2_is_fp, out_rd_is_fp, out_is_branch, out_illegal;
    logic [32*L-1:0] out_inst, out_imm;
    logic [AW*L-1:0] out_pc, out_pred_target;
    logic [GW*L-1:0] out_pred_hist;
    logic [2*L-1:0]  out_fu_type;
    logic [RW*L-1:0] out_rs1, out_rs2, out_rd;

    int checks = 0;
    int failures = 0;
    batch_t q[$];

    always #5 clk = ~clk;

    predecode_stage_n #(.LANES(L), .ADDR_W(AW), .GHR_W(GW), .RA_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_pred_hist(in_pred_hist), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .out_pred_hist(out_pred_hist), .out_fu_type(out_fu_type), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_rs1_is_fp(out_rs1_is_fp), .out_rs2_is_fp(out_rs2_is_fp),
        .out_rd_is_fp(out_rd_is_fp), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode of one valid lane, from the ISA field layout.
    function automatic ml_t ref_lane(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic pt, input logic [31:0] tgt,
                                     input logic [7:0] hist);
        ml_t m;
        int op, f3, f5, v;
        bit fpop;
        m = '0;
        m.v = 1'b1; m.inst = inst; m.pc = pc; m.pt = pt; m.tgt = tgt; m.hist = hist;
        op = int'(inst[6:0]);
        f3 = int'(inst[14:12]);
        f5 = int'(inst[31:27]);
        if (!(op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_IMM, O_OP, O_MISC,
                         O_SYS, O_LDFP, O_STFP, O_OPFP, O_MADD, O_MSUB, O_NMSUB, O_NMADD})) begin
            m.ill = 1'b1;
            return m;
        end
        m.rs1 = (op inside {O_LUI, O_AUIPC, O_JAL} || (op == O_SYS && f3 >= 4)) ? 5'd0
                : inst[19:15];
        m.rs2 = (op inside {O_OP, O_BR, O_ST, O_OPFP, O_STFP, O_MADD, O_MSUB, O_NMSUB, O_NMADD})
                ? inst[24:20] : 5'd0;
        m.rd  = (op inside {O_ST, O_STFP, O_BR}) ? 5'd0 : inst[11:7];
        v = 0;
        if (op inside {O_IMM, O_LD, O_JALR, O_LDFP, O_MISC} || (op == O_SYS && f3 < 4))
            v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
        else if (op inside {O_ST, O_STFP})
            v = int'(inst[31:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 4096 : 0);
        else if (op == O_BR)
            v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
                - (inst[31] ? 4096 : 0);
        else if (op inside {O_LUI, O_AUIPC})
            v = int'(inst & 32'hFFFF_F000);
        else if (op == O_JAL)
            v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
                - (inst[31] ? 1048576 : 0);
        else if (op == O_SYS)
            v = int'(inst[19:15]);
        m.imm = 32'(v);
        m.ui = (op inside {O_IMM, O_LD, O_ST, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC, O_MISC})
               || (op == O_SYS && f3 >= 4);
        fpop = op inside {O_OPFP, O_MADD, O_MSUB, O_NMSUB, O_NMADD};
        if (op == O_OP && inst[31:25] == 7'd1) m.fu = 2'd1;
        else if (op inside {O_LD, O_ST, O_MISC}) m.fu = 2'd2;
        else if (fpop || op inside {O_LDFP, O_STFP}) m.fu = 2'd3;
        else m.fu = 2'd0;
        m.r1f = fpop && !(op == O_OPFP && f5 inside {26, 30});
        m.r2f = fpop || op == O_STFP;
        m.rdf = op == O_LDFP || (fpop && !(op == O_OPFP && f5 inside {20, 24, 28}));
        m.br  = op inside {O_BR, O_JAL, O_JALR};
        return m;
    endfunction

    function automatic batch_t ref_batch();
        batch_t b;
        bit seen;
        b = '0;
        seen = 0;
        for (int i = 0; i < L; i++) begin
            if (in_lane_valid[i] && !seen) begin
                b[i] = ref_lane(in_inst[i*32 +: 32], in_pc[i*AW +: AW], in_pred_taken[i],
                                in_pred_target[i*AW +: AW], in_pred_hist[i*GW +: GW]);
                if (in_pred_taken[i]) seen = 1;
            end
        end
        return b;
    endfunction

    task automatic check_head(input batch_t b);
        logic [63:0] e_inst, e_pc, e_tgt, e_imm;
        logic [15:0] e_hist;
        logic [9:0]  e_rs1, e_rs2, e_rd;
        logic [3:0]  e_fu;
        logic [1:0]  e_v, e_pt, e_ui, e_r1f, e_r2f, e_rdf, e_br, e_ill;
        for (int i = 0; i < L; i++) begin
            e_inst[i*32 +: 32] = b[i].inst;  e_pc[i*32 +: 32] = b[i].pc;
            e_tgt[i*32 +: 32] = b[i].tgt;    e_imm[i*32 +: 32] = b[i].imm;
            e_hist[i*8 +: 8] = b[i].hist;    e_fu[i*2 +: 2] = b[i].fu;
            e_rs1[i*5 +: 5] = b[i].rs1;      e_rs2[i*5 +: 5] = b[i].rs2;
            e_rd[i*5 +: 5] = b[i].rd;
            e_v[i] = b[i].v;   e_pt[i] = b[i].pt;   e_ui[i] = b[i].ui;  e_r1f[i] = b[i].r1f;
            e_r2f[i] = b[i].r2f; e_rdf[i] = b[i].rdf; e_br[i] = b[i].br; e_ill[i] = b[i].ill;
        end
        chk("lane_valid", 64'(out_lane_valid), 64'(e_v));
        chk("inst", out_inst, e_inst);
        chk("pc", out_pc, e_pc);
        chk("pred_taken", 64'(out_pred_taken), 64'(e_pt));
        chk("pred_target", out_pred_target, e_tgt);
        chk("pred_hist", 64'(out_pred_hist), 64'(e_hist));
        chk("fu_type", 64'(out_fu_type), 64'(e_fu));
        chk("rs1", 64'(out_rs1), 64'(e_rs1));
        chk("rs2", 64'(out_rs2), 64'(e_rs2));
        chk("rd", 64'(out_rd), 64'(e_rd));
        chk("imm", out_imm, e_imm);
        chk("use_imm", 64'(out_use_imm), 64'(e_ui));
        chk("rs1_is_fp", 64'(out_rs1_is_fp), 64'(e_r1f));
        chk("rs2_is_fp", 64'(out_rs2_is_fp), 64'(e_r2f));
        chk("rd_is_fp", 64'(out_rd_is_fp), 64'(e_rdf));
        chk("is_branch", 64'(out_is_branch), 64'(e_br));
        chk("illegal", 64'(out_illegal), 64'(e_ill));
    endtask

    task automatic check_state();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) check_head(q[0]);
    endtask

    // Advance one clock, updating the reference queue from the inputs being driven.
    task automatic tick();
        batch_t nb;
        bit push, pop;
        nb = ref_batch();
        push = in_valid && (q.size() < 2) && !flush && (in_lane_valid & ~'0) != 0
               && nb[0].v | nb[1].v;
        pop = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(nb);
        end
        #1;
        check_state();
    endtask

    task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] lv, input logic [1:0] pt);
        in_valid = v;
        in_inst = {i1, i0};
        in_lane_valid = lv;
        in_pred_taken = pt;
        in_pc = {32'h0000_1004 + 32'(checks), 32'h0000_1000 + 32'(checks)};
        in_pred_target = {32'h8000_0000 | 32'(checks), 32'h4000_0000 | 32'(checks)};
        in_pred_hist = 16'hA55A ^ 16'(checks);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        int          fsel;
        r = $urandom();
        case ($urandom_range(0, 19))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6f;  3: op = 7'h67;  4: op = 7'h63;
            5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;  8: op = 7'h33;  9: op = 7'h0f;
            10: op = 7'h73; 11: op = 7'h07; 12: op = 7'h27; 13: op = 7'h53; 14: op = 7'h43;
            15: op = 7'h47; 16: op = 7'h4b; 17: op = 7'h4f; 18: op = 7'h7f;
            default: op = r[6:0];
        endcase
        if (op == 7'h33 && r[0]) r[31:25] = 7'd1;
        if (op == 7'h53) begin
            fsel = $urandom_range(0, 5);
            case (fsel)
                0: r[31:27] = 5'd20; 1: r[31:27] = 5'd24; 2: r[31:27] = 5'd26;
                3: r[31:27] = 5'd28; 4: r[31:27] = 5'd30; default: r[31:27] = 5'd0;
            endcase
        end
        return {r[31:7], op};
    endfunction

    initial begin
        // Reset values.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        chk("rst_inst", out_inst, 64'd0);
        chk("rst_fu_type", 64'(out_fu_type), 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // addi x1,x2,5 / add x3,x1,x2.
        out_ready = 1'b1;
        drive(1'b1, 32'h0051_0093, 32'h0020_81B3, 2'b11, 2'b00);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_rd0", 64'(out_rd[4:0]), 64'd1);
        chk("t1_rs1_0", 64'(out_rs1[4:0]), 64'd2);
        chk("t1_imm0", 64'(out_imm[31:0]), 64'd5);
        chk("t1_use_imm0", 64'(out_use_imm[0]), 64'd1);
        chk("t1_rs1_1", 64'(out_rs1[9:5]), 64'd1);
        chk("t1_rs2_1", 64'(out_rs2[9:5]), 64'd2);
        chk("t1_rd1", 64'(out_rd[9:5]), 64'd3);
        chk("t1_fu1", 64'(out_fu_type[3:2]), 64'd0);
        chk("t1_use_imm1", 64'(out_use_imm[1]), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        tick();

        // Back-to-back A,B,C with rename stalled, then drain.
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0113, 32'h0020_0193, 2'b11, 2'b00);
        tick();
        drive(1'b1, 32'h0030_0213, 32'h0040_0293, 2'b11, 2'b00);
        tick();
        chk("t2_in_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h0050_0313, 32'h0060_0393, 2'b11, 2'b00);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        chk("t2_second_is_B", 64'(out_inst[31:0]), 64'h0030_0213);
        tick();
        chk("t2_third_is_C", 64'(out_inst[31:0]), 64'h0050_0313);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        tick();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // Predicted-taken beq in lane 0 cuts lane 1.
        drive(1'b1, 32'h0020_8463, 32'h0051_0093, 2'b11, 2'b01);
        tick();
        chk("t3_lane_valid", 64'(out_lane_valid), 64'b01);
        chk("t3_is_branch0", 64'(out_is_branch[0]), 64'd1);
        chk("t3_imm0", 64'(out_imm[31:0]), 64'd8);
        chk("t3_inst1", 64'(out_inst[63:32]), 64'd0);
        chk("t3_pc1", 64'(out_pc[63:32]), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        tick();

        // Flush while full with a batch offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h0070_0413, 32'h0080_0493, 2'b11, 2'b00);
        tick();
        tick();
        drive(1'b1, 32'h0090_0513, 32'h00A0_0593, 2'b11, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        out_ready = 1'b1;
        tick();

        // Illegal encodings stay valid.
        drive(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 2'b11, 2'b00);
        tick();
        chk("t5_illegal", 64'(out_illegal), 64'b11);
        chk("t5_lane_valid", 64'(out_lane_valid), 64'b11);
        chk("t5_rd", 64'(out_rd), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        tick();

        // Async reset while full.
        out_ready = 1'b0;
        drive(1'b1, 32'h00B0_0613, 32'h00C0_0693, 2'b11, 2'b00);
        tick();
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6_valid_async", 64'(out_valid), 64'd0);
        chk("t6_ready_async", 64'(in_ready), 64'd1);
        chk("t6_lane_valid_async", 64'(out_lane_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h0051_0093, 32'h0020_81B3, 2'b11, 2'b00);
        tick();
        chk("t6_latency", 64'(out_valid), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] lv, pt;
            lv = 2'($urandom_range(0, 3));
            pt[0] = ($urandom_range(0, 3) == 0);
            pt[1] = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, rand_inst(), rand_inst(), lv, pt);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
